// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default game constants
// Used by game_sequencer and by the ball / display blocks that read its state.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_POINT  = 3'd4,
    ST_OVER   = 3'd5
  } game_state_e;

  localparam int WIN_SCORE_DEF      = 5;
  localparam int SERVE_FRAMES_DEF   = 180;
  localparam int POINT_FRAMES_DEF   = 60;
  localparam int SPEEDUP_FRAMES_DEF = 600;
  localparam int MIN_SPEED_DEF      = 2;
  localparam int MAX_SPEED_DEF      = 5;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - tick-gated frame counter with clear and terminal-count pulse
// Ports: clk, reset_n (async, active-low); tick (frame strobe); en (count enable);
//        clr (synchronous clear, wins over counting); last (terminal value);
//        count (current value); tc (high in the cycle the count wraps from last to 0).
module frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  assign tc    = en & tick & ~clr & (count_q == last);
  assign count = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && tick) begin
      count_q <= tc ? '0 : count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game flow FSM: serve countdown, play, pause, points, game over
// Ports: clk, reset_n (async, active-low); refresh_tick (frame strobe);
//        start_pulse, pause_pulse, point_p1, point_p2 (one-cycle event pulses);
//        game_active, serve, score_p1, score_p2, ball_speed, countdown,
//        game_over, winner, state (all registered or decoded from registers).
module game_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE      = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES   = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES   = POINT_FRAMES_DEF,
  parameter int SPEEDUP_FRAMES = SPEEDUP_FRAMES_DEF,
  parameter int MIN_SPEED      = MIN_SPEED_DEF,
  parameter int MAX_SPEED      = MAX_SPEED_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refresh_tick,
  input  logic       start_pulse,
  input  logic       pause_pulse,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic       game_active,
  output logic       serve,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [3:0] ball_speed,
  output logic [1:0] countdown,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int PH_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int PH_W   = width_for(PH_MAX);
  localparam int SP_W   = width_for(SPEEDUP_FRAMES);

  game_state_e state_q;
  logic        active_q, serve_q, over_q;
  logic [3:0]  score1_q, score2_q, speed_q;
  logic [1:0]  winner_q;

  logic [PH_W-1:0] phase_cnt, phase_last;
  logic [SP_W-1:0] speed_cnt;
  logic            phase_en, phase_tc, speed_en, speed_clr, speed_tc;

  // Phase timer only runs in SERVE/POINT and is held at zero elsewhere, so every
  // entry into a phase starts from zero; POINT->SERVE is covered by the wrap.
  assign phase_en   = (state_q == ST_SERVE) || (state_q == ST_POINT);
  assign phase_last = (state_q == ST_SERVE) ? PH_W'(SERVE_FRAMES - 1) : PH_W'(POINT_FRAMES - 1);

  // Speed timer persists across points; it only restarts with a new game.
  assign speed_en  = (state_q == ST_PLAY);
  assign speed_clr = (state_q == ST_IDLE) || (state_q == ST_OVER);

  frame_timer #(.WIDTH(PH_W)) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (refresh_tick),
    .en      (phase_en),
    .clr     (~phase_en),
    .last    (phase_last),
    .count   (phase_cnt),
    .tc      (phase_tc)
  );

  frame_timer #(.WIDTH(SP_W)) u_speed_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (refresh_tick),
    .en      (speed_en),
    .clr     (speed_clr),
    .last    (SP_W'(SPEEDUP_FRAMES - 1)),
    .count   (speed_cnt),
    .tc      (speed_tc)
  );

  logic [3:0] new1, new2;
  logic       win1, win2;
  assign new1 = score1_q + 4'(point_p1);
  assign new2 = score2_q + 4'(point_p2);
  assign win1 = (new1 == 4'(WIN_SCORE));
  assign win2 = (new2 == 4'(WIN_SCORE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
      serve_q  <= 1'b0;
      over_q   <= 1'b0;
      score1_q <= '0;
      score2_q <= '0;
      speed_q  <= 4'(MIN_SPEED);
      winner_q <= WINNER_NONE;
    end else begin
      serve_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_pulse) begin
            state_q  <= ST_SERVE;
            serve_q  <= 1'b1;
            over_q   <= 1'b0;
            score1_q <= '0;
            score2_q <= '0;
            speed_q  <= 4'(MIN_SPEED);
            winner_q <= WINNER_NONE;
          end
        end
        ST_SERVE: begin
          if (phase_tc) begin
            state_q  <= ST_PLAY;
            active_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (speed_tc) begin
            speed_q <= (speed_q < 4'(MAX_SPEED)) ? speed_q + 4'd1 : 4'(MIN_SPEED);
          end
          // A point in the same cycle as pause wins; the pause is dropped.
          if (point_p1 || point_p2) begin
            score1_q <= new1;
            score2_q <= new2;
            active_q <= 1'b0;
            if (win1 || win2) begin
              state_q  <= ST_OVER;
              over_q   <= 1'b1;
              winner_q <= {win2, win1};
            end else begin
              state_q <= ST_POINT;
            end
          end else if (pause_pulse) begin
            state_q  <= ST_PAUSED;
            active_q <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (pause_pulse) begin
            state_q  <= ST_PLAY;
            active_q <= 1'b1;
          end
        end
        ST_POINT: begin
          if (phase_tc) begin
            state_q <= ST_SERVE;
            serve_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // Serve digit: 3 - count*3/SERVE_FRAMES, decoded from the registered phase count.
  logic [31:0] cd_step;
  always_comb begin
    cd_step   = (32'(phase_cnt) * 32'd3) / 32'(SERVE_FRAMES);
    countdown = 2'b00;
    if (state_q == ST_SERVE) begin
      countdown = 2'(32'd3 - cd_step);
    end
  end

  assign game_active = active_q;
  assign serve       = serve_q;
  assign score_p1    = score1_q;
  assign score_p2    = score2_q;
  assign ball_speed  = speed_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;
  import game_pkg::*;

  localparam int WIN = 2;
  localparam int SRV = 6;
  localparam int PNT = 3;
  localparam int SPD = 4;
  localparam int MINS = 2;
  localparam int MAXS = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic refresh_tick = 1'b0, start_pulse = 1'b0, pause_pulse = 1'b0;
  logic point_p1 = 1'b0, point_p2 = 1'b0;
  logic game_active, serve, game_over;
  logic [3:0] score_p1, score_p2, ball_speed;
  logic [1:0] countdown, winner;
  logic [2:0] state;

  always #5 clk = ~clk;

  game_sequencer #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .POINT_FRAMES(PNT),
    .SPEEDUP_FRAMES(SPD), .MIN_SPEED(MINS), .MAX_SPEED(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .refresh_tick(refresh_tick),
    .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .point_p1(point_p1), .point_p2(point_p2),
    .game_active(game_active), .serve(serve),
    .score_p1(score_p1), .score_p2(score_p2), .ball_speed(ball_speed),
    .countdown(countdown), .game_over(game_over), .winner(winner), .state(state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: phases tracked as remaining ticks, speed as frames played.
  game_state_e m_state;
  int m_s1, m_s2, m_speed, m_left, m_played, m_winner;
  bit m_serve, m_over;

  task automatic model_reset();
    m_state = ST_IDLE; m_s1 = 0; m_s2 = 0; m_speed = MINS; m_left = 0;
    m_played = 0; m_winner = 0; m_serve = 0; m_over = 0;
  endtask

  task automatic model_step(input bit tk, input bit st, input bit pa, input bit p1, input bit p2);
    m_serve = 0;
    case (m_state)
      ST_IDLE, ST_OVER:
        if (st) begin
          m_state = ST_SERVE; m_s1 = 0; m_s2 = 0; m_winner = 0; m_over = 0;
          m_speed = MINS; m_played = 0; m_left = SRV; m_serve = 1;
        end
      ST_SERVE:
        if (tk) begin
          m_left--;
          if (m_left == 0) m_state = ST_PLAY;
        end
      ST_PLAY: begin
        if (tk) begin
          m_played++;
          if (m_played % SPD == 0) m_speed = (m_speed == MAXS) ? MINS : m_speed + 1;
        end
        if (p1 || p2) begin
          m_s1 += int'(p1); m_s2 += int'(p2);
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_state = ST_OVER; m_over = 1;
            m_winner = (m_s1 == WIN ? 1 : 0) + (m_s2 == WIN ? 2 : 0);
          end else begin
            m_state = ST_POINT; m_left = PNT;
          end
        end else if (pa) m_state = ST_PAUSED;
      end
      ST_PAUSED: if (pa) m_state = ST_PLAY;
      ST_POINT:
        if (tk) begin
          m_left--;
          if (m_left == 0) begin m_state = ST_SERVE; m_left = SRV; m_serve = 1; end
        end
      default: m_state = ST_IDLE;
    endcase
  endtask

  task automatic check_all(input string ctx);
    int exp_cd;
    exp_cd = (m_state == ST_SERVE) ? 3 - ((SRV - m_left) * 3 / SRV) : 0;
    check_eq({ctx, ".state"}, int'(state), int'(m_state));
    check_eq({ctx, ".active"}, int'(game_active), (m_state == ST_PLAY) ? 1 : 0);
    check_eq({ctx, ".serve"}, int'(serve), int'(m_serve));
    check_eq({ctx, ".score_p1"}, int'(score_p1), m_s1);
    check_eq({ctx, ".score_p2"}, int'(score_p2), m_s2);
    check_eq({ctx, ".speed"}, int'(ball_speed), m_speed);
    check_eq({ctx, ".countdown"}, int'(countdown), exp_cd);
    check_eq({ctx, ".game_over"}, int'(game_over), int'(m_over));
    check_eq({ctx, ".winner"}, int'(winner), m_winner);
  endtask

  // One clock: drive at negedge, advance model, check at the next negedge.
  task automatic cyc(input bit tk, input bit st, input bit pa, input bit p1, input bit p2,
                     input string ctx);
    refresh_tick = tk; start_pulse = st; pause_pulse = pa; point_p1 = p1; point_p2 = p2;
    model_step(tk, st, pa, p1, p2);
    @(negedge clk);
    refresh_tick = 0; start_pulse = 0; pause_pulse = 0; point_p1 = 0; point_p2 = 0;
    check_all(ctx);
  endtask

  task automatic ticks(input int n, input string ctx);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, ctx);
  endtask

  task automatic do_reset(input string ctx);
    #2 reset_n = 0;
    model_reset();
    #1 check_all(ctx);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    cyc(0, 0, 0, 0, 0, ctx);
  endtask

  int cd_seq [6] = '{3, 3, 2, 2, 1, 1};
  int sp_seq [4] = '{3, 4, 5, 2};

  initial begin
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset_n = 1;
    cyc(0, 0, 0, 0, 0, "idle");

    // Serve countdown then play.
    cyc(0, 1, 0, 0, 0, "start");
    check_eq("serve_after_start", int'(serve), 1);
    for (int i = 0; i < 6; i++) begin
      check_eq("cd_seq", int'(countdown), cd_seq[i]);
      cyc(1, 0, 0, 0, 0, "serve_cd");
    end
    check_eq("play_active", int'(game_active), 1);

    // Two P1 points end the game.
    cyc(0, 0, 0, 1, 0, "p1_point");
    check_eq("p1_score1", int'(score_p1), 1);
    ticks(PNT, "point_pause");
    check_eq("reserve_pulse", int'(serve), 1);
    ticks(SRV, "serve2");
    cyc(0, 0, 0, 1, 0, "p1_win");
    check_eq("p1_winner", int'(winner), 1);
    check_eq("p1_over", int'(game_over), 1);

    // Draw at 1-1.
    cyc(0, 1, 0, 0, 0, "start2");
    ticks(SRV, "s");
    cyc(0, 0, 0, 1, 0, "d1");
    ticks(PNT + SRV, "s");
    cyc(0, 0, 0, 0, 1, "d2");
    ticks(PNT + SRV, "s");
    cyc(0, 0, 0, 1, 1, "draw");
    check_eq("draw_winner", int'(winner), 3);
    check_eq("draw_scores", int'({score_p1, score_p2}), 8'h22);

    // Speed ramp, then pause freezes it.
    cyc(0, 1, 0, 0, 0, "start3");
    ticks(SRV, "s");
    for (int i = 0; i < 4; i++) begin
      ticks(SPD, "ramp");
      check_eq("speed_seq", int'(ball_speed), sp_seq[i]);
    end
    cyc(0, 0, 1, 0, 0, "pause");
    ticks(10, "paused");
    cyc(0, 0, 0, 1, 0, "paused_point");
    check_eq("paused_score", int'(score_p1), 0);
    check_eq("paused_speed", int'(ball_speed), 2);
    cyc(0, 0, 1, 0, 0, "resume");
    ticks(5, "resumed");
    cyc(0, 0, 1, 0, 1, "point_beats_pause");
    check_eq("pb_state", int'(state), int'(ST_POINT));

    // Reset during POINT.
    ticks(1, "point");
    do_reset("mid_reset");
    check_eq("mr_serve", int'(serve), 0);
    check_eq("mr_speed", int'(ball_speed), 2);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rnd_reset");
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 24) == 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
